// File: rtl/reg_mem_pkg.sv
// Shared constants and helpers for the flip-flop register-file memory.
package reg_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_ADDR_BITS  = 3;

  function automatic int depth(input int addrBits);
    return 1 << addrBits;
  endfunction

endpackage

// File: rtl/reg_mem_word.sv
// One storage word: async-cleared register that loads on a clock edge when selected.
module reg_mem_word
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (sel_i) begin
      value_d = d_i;
    end
  end

  // Reset takes priority, so a write coinciding with rst is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q_o = value_q;

endmodule

// File: rtl/reg_mem.sv
// Register-file memory: shared address, synchronous write, combinational read.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int DEPTH = depth(ADDR_BITS);

  logic [DEPTH-1:0]      wordSel;
  logic [DATA_WIDTH-1:0] wordQ [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : gWords
    assign wordSel[i] = wen && (addr == ADDR_BITS'(i));

    reg_mem_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) uWord (
      .clk  (clk),
      .rst  (rst),
      .sel_i(wordSel[i]),
      .d_i  (data_in),
      .q_o  (wordQ[i])
    );
  end

  // Depth is a full power of two, so every addr value selects a real word.
  assign data_out = wordQ[addr];

endmodule

// File: tb/tb_reg_mem.sv
// Directed self-checking bench for reg_mem at DATA_WIDTH=8, ADDR_BITS=5.
module tb_reg_mem;

  localparam int DW = 8;
  localparam int AB = 5;

  logic [AB-1:0] addr;
  logic [DW-1:0] data_in;
  logic          wen;
  logic          clk;
  logic          rst;
  logic [DW-1:0] data_out;

  int assertCount = 0;
  int failCount   = 0;

  reg_mem #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (AB)
  ) dut (
    .addr    (addr),
    .data_in (data_in),
    .wen     (wen),
    .clk     (clk),
    .data_out(data_out),
    .rst     (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    wen = 1'b0;
    data_in = 8'h00;
    addr = '0;
    #2;
    for (int i = 0; i < 32; i++) begin
      addr = AB'(i);
      #1;
      assertCount++;
      if (data_out !== 8'h00) begin
        failCount++;
        $display("[TB] FAIL reset_addr%0d: got %h expected 00", i, data_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      addr = AB'(i);
      data_in = DW'(i);
      wen = 1'b1;
    end
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr = AB'(i);
      #1;
      assertCount++;
      if (data_out !== DW'(i)) begin
        failCount++;
        $display("[TB] FAIL fill_addr%0d: got %h expected %h", i, data_out, DW'(i));
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    wen = 1'b0;
    data_in = 8'hFF;
    addr = 5'd7;
    repeat (10) @(posedge clk);
    #1;
    assertCount++;
    if (data_out !== 8'h07) begin
      failCount++;
      $display("[TB] FAIL hold_addr7: got %h expected 07", data_out);
    end
    addr = 5'd31;
    #1;
    assertCount++;
    if (data_out !== 8'h1F) begin
      failCount++;
      $display("[TB] FAIL hold_addr31: got %h expected 1f", data_out);
    end
  endtask

  task automatic test_overwrite();
    @(negedge clk);
    addr = 5'd5;
    data_in = 8'hA5;
    wen = 1'b1;
    #1;
    // Before the edge the old contents must still be visible (no bypass).
    assertCount++;
    if (data_out !== 8'h05) begin
      failCount++;
      $display("[TB] FAIL overwrite_pre_edge: got %h expected 05", data_out);
    end
    @(posedge clk);
    #1;
    assertCount++;
    if (data_out !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL overwrite_post_edge: got %h expected a5", data_out);
    end
    wen = 1'b0;
    addr = 5'd4;
    #1;
    assertCount++;
    if (data_out !== 8'h04) begin
      failCount++;
      $display("[TB] FAIL overwrite_neighbor4: got %h expected 04", data_out);
    end
    addr = 5'd6;
    #1;
    assertCount++;
    if (data_out !== 8'h06) begin
      failCount++;
      $display("[TB] FAIL overwrite_neighbor6: got %h expected 06", data_out);
    end
    addr = 5'd5;
    #1;
    assertCount++;
    if (data_out !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL overwrite_readback: got %h expected a5", data_out);
    end
  endtask

  task automatic test_async_read();
    @(posedge clk);
    #1;
    wen = 1'b0;
    addr = 5'd3;
    #1;
    assertCount++;
    if (data_out !== 8'h03) begin
      failCount++;
      $display("[TB] FAIL async_addr3: got %h expected 03", data_out);
    end
    addr = 5'd9;
    #1;
    assertCount++;
    if (data_out !== 8'h09) begin
      failCount++;
      $display("[TB] FAIL async_addr9: got %h expected 09", data_out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wen = 1'b1;
    addr = 5'd2;
    data_in = 8'h77;
    #1;
    rst = 1'b1;
    #1;
    assertCount++;
    if (data_out !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_mid_immediate: got %h expected 00", data_out);
    end
    @(posedge clk);
    #1;
    assertCount++;
    if (data_out !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_mid_write_discarded: got %h expected 00", data_out);
    end
    @(negedge clk);
    wen = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    assertCount++;
    if (data_out !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_mid_addr2: got %h expected 00", data_out);
    end
    addr = 5'd31;
    #1;
    assertCount++;
    if (data_out !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_mid_addr31: got %h expected 00", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_overwrite();
    test_async_read();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
